mem_stage_sram_ctrl: RTL and testbench



---
 rtl/mem_stage_sram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Memory stage placed after the EX/MEM register. Each 32-bit load or store is
// split into two 16-bit SRAM half-word accesses: the low half first, then the
// high half. Each access is held on the bus for WAIT_CYCLES cycles. While an
// access is in flight, `ready` is held low so the upstream pipeline freezes.
// The write-back bundle and the assembled load data go forward to MEM/WB.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   MEM_R_EN       load request
//   MEM_W_EN       store request (a store wins when both requests are set)
//   WB_EN          write-back enable from EX/MEM
//   ALU_Res        byte address for memory ops, or the plain ALU result
//   Val_Rm         store data
//   Dest           destination register
//   ready          1 = pipeline may advance, 0 = freeze upstream stages
//   WB_EN_out      WB_EN gated by ready
//   MEM_R_EN_out   pass-through of MEM_R_EN
//   ALU_Res_out    pass-through of ALU_Res
//   Dest_out       pass-through of Dest
//   Mem_Data       registered load data
//   sram_addr      SRAM half-word address
//   sram_dq_out    write data driven to the SRAM
//   sram_dq_in     read data returned by the SRAM
//   sram_dq_oe     1 = drive sram_dq_out onto the data bus
//   sram_we_n      active-low write strobe
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic                   WB_EN,
  input  logic [31:0]            ALU_Res,
  input  logic [31:0]            Val_Rm,
  input  logic [3:0]             Dest,
  output logic                   ready,
  output logic                   WB_EN_out,
  output logic                   MEM_R_EN_out,
  output logic [31:0]            ALU_Res_out,
  output logic [3:0]             Dest_out,
  output logic [31:0]            Mem_Data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      mem_data_reg;

  logic        req;
  logic        is_store;
  logic        in_access;
  logic        last_cycle;
  logic [31:0] word;
  logic [32:0] half_addr;
  logic        unused_addr_bits;

  assign req        = MEM_R_EN | MEM_W_EN;
  // A simultaneous read and write request is treated as a store.
  assign is_store   = MEM_W_EN;
  assign in_access  = (state_reg == LOW) || (state_reg == HIGH);
  assign last_cycle = (cnt_reg == CNT_LAST);

  // Word index relative to the SRAM base; the byte offset bits drop out in
  // the shift. The half-word select bit is appended below it.
  assign word      = (ALU_Res - 32'(BASE_ADDR)) >> 2;
  assign half_addr = {word, (state_reg == HIGH)};

  // Address bits above the SRAM width are discarded; wrap-around is intended.
  assign unused_addr_bits = ^half_addr[32:SRAM_ADDR_W];

  // ---------------------------------------------------------------------------
  // Sequencer: state, wait counter and load-data register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      mem_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (req) begin
            state_reg <= LOW;
          end
        end
        LOW: begin
          if (last_cycle) begin
            cnt_reg   <= '0;
            state_reg <= HIGH;
            if (!is_store) begin
              mem_data_reg[15:0] <= sram_dq_in;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HIGH: begin
          if (last_cycle) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            if (!is_store) begin
              mem_data_reg[31:16] <= sram_dq_in;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // Always pass back through IDLE so a following request is seen
          // fresh rather than chained onto this one.
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline handshake and pass-through bundle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    case (state_reg)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign WB_EN_out    = WB_EN & ready;
  assign MEM_R_EN_out = MEM_R_EN;
  assign ALU_Res_out  = ALU_Res;
  assign Dest_out     = Dest;
  assign Mem_Data     = mem_data_reg;

  // ---------------------------------------------------------------------------
  // SRAM bus. The bus is driven only while in LOW or HIGH; otherwise it idles
  // with the strobe inactive and the data and address at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = 16'h0000;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (in_access) begin
      sram_addr = half_addr[SRAM_ADDR_W-1:0];
      if (is_store) begin
        sram_dq_out = (state_reg == HIGH) ? Val_Rm[31:16] : Val_Rm[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//
// Testbench for mem_stage_sram_ctrl with the default parameters
// (BASE_ADDR=1024, WAIT_CYCLES=2, SRAM_ADDR_W=18). A small half-word SRAM
// model sits on the bus. Transactions come from a vector table; each expected
// result is queued when the transaction is driven and compared when the DUT
// raises ready. Reset-during-store is a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN, WB_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest;
  logic        ready, WB_EN_out, MEM_R_EN_out;
  logic [31:0] ALU_Res_out, Mem_Data;
  logic [3:0]  Dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest),
    .ready(ready), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
    .ALU_Res_out(ALU_Res_out), .Dest_out(Dest_out), .Mem_Data(Mem_Data),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Half-word SRAM model, preloaded while sram_init is high.
  logic [15:0] sram [0:63];
  logic        sram_init;

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 64; i++) sram[i] <= 16'h0000;
      sram[0] <= 16'hBEEF;
      sram[1] <= 16'hDEAD;
      sram[2] <= 16'hC0DE;
      sram[3] <= 16'hCAFE;
      sram[6] <= 16'h1111;
      sram[7] <= 16'h2222;
      sram[9] <= 16'hAAAA;
    end else if (!sram_we_n) begin
      sram[sram_addr[5:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = sram[sram_addr[5:0]];

  typedef struct {
    logic        r;
    logic        w;
    logic        wb;
    logic [31:0] alu;
    logic [31:0] val;
    logic [3:0]  dest;
    logic [17:0] lo;     // expected half-word address during LOW
    logic [31:0] mem;    // expected Mem_Data once ready rises
  } vec_t;

  vec_t        vecs [8];
  vec_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   lat;
    bit   seen;
    logic low, high, st;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    vec_t e;
    lat  = (v.r | v.w) ? 2 * WAIT + 1 : 0;
    seen = 0;
    st   = v.w;
    MEM_R_EN = v.r; MEM_W_EN = v.w; WB_EN = v.wb;
    ALU_Res = v.alu; Val_Rm = v.val; Dest = v.dest;
    sb.push_back(v);
    for (int c = 0; c <= lat + 4; c++) begin
      @(negedge clk);
      low    = (v.r | v.w) && (c >= 1) && (c <= WAIT);
      high   = (v.r | v.w) && (c >= WAIT + 1) && (c <= 2 * WAIT);
      e_addr = low ? v.lo : (high ? v.lo + 18'd1 : 18'd0);
      e_dq   = (st && low) ? v.val[15:0] : ((st && high) ? v.val[31:16] : 16'h0000);
      chk("ready", 32'(ready), 32'(c == lat));
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("sram_we_n", 32'(sram_we_n), 32'(!(st && (low || high))));
      chk("sram_dq_oe", 32'(sram_dq_oe), 32'(st && (low || high)));
      chk("sram_dq_out", 32'(sram_dq_out), 32'(e_dq));
      chk("wb_en_out", 32'(WB_EN_out), 32'(v.wb && (c == lat)));
      if (c == 0) chk("mem_data_hold", Mem_Data, last_mem);
      if (ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("mem_data", Mem_Data, e.mem);
        chk("dest_out", 32'(Dest_out), 32'(e.dest));
        chk("alu_res_out", ALU_Res_out, e.alu);
        chk("mem_r_en_out", 32'(MEM_R_EN_out), 32'(e.r));
        last_mem = e.mem;
        seen = 1;
        $display("txn r=%0b w=%0b alu=%0d val=%h -> cycles=%0d mem_data=%h", v.r, v.w,
                 v.alu, v.val, c, Mem_Data);
      end
      @(posedge clk); #1;
      if (seen) break;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout actual=no_ready required=ready_within_%0d", lat + 4);
      sb.delete();
    end
  endtask

  initial begin
    //        r  w  wb  alu   val           dest  lo  mem
    vecs[0] = '{1, 0, 1, 1024, 32'h0,        4'd1, 0,  32'hDEADBEEF};
    vecs[1] = '{0, 1, 0, 1032, 32'h12345678, 4'd0, 4,  32'hDEADBEEF};
    vecs[2] = '{0, 0, 1, 7,    32'h0,        4'd3, 0,  32'hDEADBEEF};
    vecs[3] = '{1, 0, 1, 1024, 32'h0,        4'd2, 0,  32'hDEADBEEF};
    vecs[4] = '{1, 0, 1, 1028, 32'h0,        4'd5, 2,  32'hCAFEC0DE};
    vecs[5] = '{1, 1, 0, 1024, 32'h0BADF00D, 4'd0, 0,  32'hCAFEC0DE};
    vecs[6] = '{1, 0, 1, 1032, 32'h0,        4'd6, 4,  32'h12345678};
    vecs[7] = '{1, 0, 1, 1024, 32'h0,        4'd7, 0,  32'h0BADF00D};

    rst = 1; sram_init = 1;
    MEM_R_EN = 0; MEM_W_EN = 0; WB_EN = 0;
    ALU_Res = 0; Val_Rm = 0; Dest = 0;
    last_mem = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0; sram_init = 0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe", 32'(sram_dq_oe), 32'd0);
    chk("reset_mem_data", Mem_Data, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset during the second LOW cycle of a store to half-words 8/9.
    MEM_R_EN = 0; MEM_W_EN = 1; WB_EN = 0;
    ALU_Res = 1040; Val_Rm = 32'h99997777; Dest = 0;
    @(posedge clk); #1;                  // cycle 1: first LOW cycle
    @(posedge clk); #1;                  // cycle 2: second LOW cycle
    @(negedge clk);
    chk("rst_mid_low_we_n", 32'(sram_we_n), 32'd0);
    chk("rst_mid_low_addr", 32'(sram_addr), 32'd8);
    rst = 1;
    @(posedge clk); #1;                  // aborted on this edge
    rst = 0; MEM_W_EN = 0;
    @(negedge clk);
    chk("rst_abort_ready", 32'(ready), 32'd1);
    chk("rst_abort_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_abort_addr", 32'(sram_addr), 32'd0);
    chk("rst_abort_mem_data", Mem_Data, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_high_write", 32'(sram[9]), 32'h0000AAAA);
    chk("rst_low_write", 32'(sram[8]), 32'h00007777);
    $display("txn reset-mid-store alu=1040 -> aborted mem_data=%h", Mem_Data);
    last_mem = 0;

    // Unaligned byte address: ALU_Res[1:0] are ignored, so this is word 3.
    run_txn('{1, 0, 1, 1037, 32'h0, 4'd9, 6, 32'h22221111});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
